// File: rtl/riscv_core_div_pkg.sv
// rtl/riscv_core_div_pkg.sv - shared types and op decode helpers for the radix-2 divider
package riscv_core_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // op[0] clear selects the signed variants (DIV/REM)
  function automatic logic op_is_signed(div_op_e op);
    logic [1:0] raw;
    raw = op;
    return ~raw[0];
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    logic [1:0] raw;
    raw = op;
    return raw[1];
  endfunction

endpackage

// File: rtl/riscv_core_div_step.sv
// rtl/riscv_core_div_step.sv - one combinational non-restoring iteration on an (XLEN+1)-bit accumulator
module riscv_core_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   acc_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] acc_sh;
  logic [XLEN:0] dvsr_ext;

  always_comb begin
    acc_sh   = {acc[XLEN-1:0], quo[XLEN-1]};
    dvsr_ext = {1'b0, dvsr};
    // the sign of the accumulator before the shift picks subtract or add
    acc_next = acc[XLEN] ? (acc_sh + dvsr_ext) : (acc_sh - dvsr_ext);
    quo_next = {quo[XLEN-2:0], ~acc_next[XLEN]};
  end

endmodule

// File: rtl/riscv_core_div_unit.sv
// rtl/riscv_core_div_unit.sv - iterative RV32M/RV64M divider; RISCV_CORE_DIV_FAST_PATH_EN bypasses /0 and overflow
module riscv_core_div_unit
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_div_clk,
  input  logic             i_div_rstn,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  input  logic [1:0]       i_div_op,
  input  logic [XLEN-1:0]  i_div_dividend,
  input  logic [XLEN-1:0]  i_div_divisor,
  input  logic [TAG_W-1:0] i_div_tag,
  input  logic             i_div_flush,
  output logic             o_div_valid,
  input  logic             i_div_ready,
  output logic [XLEN-1:0]  o_div_result,
  output logic [TAG_W-1:0] o_div_tag,
  output logic             o_div_busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [XLEN:0]    acc_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qneg_q, rneg_q, rem_q, dz_q, ovf_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  result_q;

  div_op_e          op_in;
  logic             sgn_in, rem_in, dvd_neg, dvs_neg, dz_in, ovf_in;
  logic [XLEN-1:0]  dvd_mag, dvs_mag, fast_res;
  logic             accept, fast_take;

  logic [XLEN:0]    acc_step;
  logic [XLEN-1:0]  quo_step;
  logic [XLEN:0]    r_full;
  logic [XLEN-1:0]  r_fix, q_fix, fix_res;

  always_comb begin
    op_in    = div_op_e'(i_div_op);
    sgn_in   = op_is_signed(op_in);
    rem_in   = op_is_rem(op_in);
    dvd_neg  = sgn_in & i_div_dividend[XLEN-1];
    dvs_neg  = sgn_in & i_div_divisor[XLEN-1];
    dvd_mag  = dvd_neg ? -i_div_dividend : i_div_dividend;
    dvs_mag  = dvs_neg ? -i_div_divisor : i_div_divisor;
    dz_in    = (i_div_divisor == '0);
    ovf_in   = sgn_in & (i_div_dividend == MIN_NEG) & (i_div_divisor == '1);
    fast_res = dz_in ? (rem_in ? i_div_dividend : '1)
                     : (rem_in ? '0 : i_div_dividend);
  end

  assign accept = i_div_valid & (state_q == IDLE) & ~i_div_flush;

`ifdef RISCV_CORE_DIV_FAST_PATH_EN
  assign fast_take = dz_in | ovf_in;
`else
  assign fast_take = 1'b0;
`endif

  riscv_core_div_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .quo      (quo_q),
    .dvsr     (dvsr_q),
    .acc_next (acc_step),
    .quo_next (quo_step)
  );

  // With a zero divisor the accumulator ends holding |dividend|, so the signed
  // remainder path already reproduces the dividend; only the quotient is forced.
  always_comb begin
    r_full = acc_q[XLEN] ? (acc_q + {1'b0, dvsr_q}) : acc_q;
    r_fix  = rneg_q ? -r_full[XLEN-1:0] : r_full[XLEN-1:0];
    q_fix  = qneg_q ? -quo_q : quo_q;
    if (dz_q) begin
      q_fix = '1;
    end else if (ovf_q) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    fix_res = rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge i_div_clk or negedge i_div_rstn) begin
    if (!i_div_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_div_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_div_valid) state_d = fast_take ? DONE : CALC;
        CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (i_div_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_div_clk or negedge i_div_rstn) begin
    if (!i_div_rstn) begin
      acc_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rem_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      acc_q  <= '0;
      quo_q  <= dvd_mag;
      dvsr_q <= dvs_mag;
      cnt_q  <= CNT_W'(XLEN);
      qneg_q <= dvd_neg ^ dvs_neg;
      rneg_q <= dvd_neg;
      rem_q  <= rem_in;
      dz_q   <= dz_in;
      ovf_q  <= ovf_in;
      tag_q  <= i_div_tag;
      if (fast_take) result_q <= fast_res;
    end else if (state_q == CALC) begin
      acc_q <= acc_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (state_q == FIX) begin
      result_q <= fix_res;
    end
  end

  assign o_div_ready  = (state_q == IDLE);
  assign o_div_busy   = (state_q != IDLE);
  assign o_div_valid  = (state_q == DONE);
  assign o_div_result = result_q;
  assign o_div_tag    = tag_q;

endmodule

// File: tb/tb_riscv_core_div_unit.sv
// tb/tb_riscv_core_div_unit.sv - randomized self-checking bench for riscv_core_div_unit
module tb_riscv_core_div_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic             clk;
  logic             rstn;
  logic             i_div_valid;
  logic             o_div_ready;
  logic [1:0]       i_div_op;
  logic [XLEN-1:0]  i_div_dividend;
  logic [XLEN-1:0]  i_div_divisor;
  logic [TAG_W-1:0] i_div_tag;
  logic             i_div_flush;
  logic             o_div_valid;
  logic             i_div_ready;
  logic [XLEN-1:0]  o_div_result;
  logic [TAG_W-1:0] o_div_tag;
  logic             o_div_busy;

  int n_cmp = 0;
  int n_mis = 0;

  riscv_core_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_div_clk      (clk),
    .i_div_rstn     (rstn),
    .i_div_valid    (i_div_valid),
    .o_div_ready    (o_div_ready),
    .i_div_op       (i_div_op),
    .i_div_dividend (i_div_dividend),
    .i_div_divisor  (i_div_divisor),
    .i_div_tag      (i_div_tag),
    .i_div_flush    (i_div_flush),
    .o_div_valid    (o_div_valid),
    .i_div_ready    (i_div_ready),
    .o_div_result   (o_div_result),
    .o_div_tag      (o_div_tag),
    .o_div_busy     (o_div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? MINV : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 0) || (!op[0] && a == MINV && b == 32'hFFFF_FFFF);
`ifdef RISCV_CORE_DIV_FAST_PATH_EN
    return special ? 1 : XLEN + 2;
`else
    return (special || !special) ? XLEN + 2 : XLEN + 2;
`endif
  endfunction

  task automatic scramble();
    i_div_op       = 2'($urandom);
    i_div_dividend = $urandom;
    i_div_divisor  = $urandom;
    i_div_tag      = TAG_W'($urandom);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"},  o_div_ready, 1);
    chk({pfx, "_valid"},  o_div_valid, 0);
    chk({pfx, "_busy"},   o_div_busy, 0);
    chk({pfx, "_result"}, o_div_result, 0);
    chk({pfx, "_tag"},    o_div_tag, 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int hold);
    int edges;
    logic [31:0] exp_res;
    exp_res = ref_div(op, a, b);
    @(negedge clk);
    chk("ready_idle", o_div_ready, 1);
    i_div_valid    = 1'b1;
    i_div_op       = op;
    i_div_dividend = a;
    i_div_divisor  = b;
    i_div_tag      = tag;
    @(negedge clk);
    i_div_valid = 1'b0;
    scramble();
    edges = 0;
    while (!o_div_valid && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    chk("latency", edges + 1, ref_lat(op, a, b));
    chk("result", o_div_result, exp_res);
    chk("tag", o_div_tag, tag);
    for (int i = 0; i < hold; i++) begin
      i_div_valid = 1'b1;
      scramble();
      @(negedge clk);
      chk("hold_valid", o_div_valid, 1);
      chk("hold_result", o_div_result, exp_res);
      chk("hold_tag", o_div_tag, tag);
      chk("hold_ready", o_div_ready, 0);
    end
    i_div_valid = 1'b0;
    i_div_ready = 1'b1;
    @(negedge clk);
    i_div_ready = 1'b0;
    chk("release_valid", o_div_valid, 0);
    chk("release_ready", o_div_ready, 1);
  endtask

  task automatic start_and_wait(input int cycles);
    @(negedge clk);
    i_div_valid    = 1'b1;
    i_div_op       = 2'b01;
    i_div_dividend = 32'd1000;
    i_div_divisor  = 32'd3;
    i_div_tag      = 5'd9;
    @(negedge clk);
    i_div_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("mid_busy", o_div_busy, 1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (o_div_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int mode;
    rstn = 1'b0;
    i_div_valid = 1'b0;
    i_div_flush = 1'b0;
    i_div_ready = 1'b0;
    i_div_op = 2'b00;
    i_div_dividend = '0;
    i_div_divisor = '0;
    i_div_tag = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;

    run_op(2'b01, 32'd100, 32'd7, 5'd3, 0);
    run_op(2'b11, 32'd100, 32'd7, 5'd4, 0);
    run_op(2'b00, -32'sd7, 32'd2, 5'd5, 0);
    run_op(2'b10, -32'sd7, 32'd2, 5'd6, 0);
    run_op(2'b10, 32'd7, -32'sd2, 5'd7, 0);
    run_op(2'b01, 32'd5, 32'd0, 5'd8, 0);
    run_op(2'b10, 32'd5, 32'd0, 5'd10, 0);
    run_op(2'b00, MINV, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(2'b10, MINV, 32'hFFFF_FFFF, 5'd12, 0);
    run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd13, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 10);

    // flush together with valid in IDLE must not accept
    @(negedge clk);
    i_div_valid = 1'b1;
    i_div_flush = 1'b1;
    @(negedge clk);
    i_div_valid = 1'b0;
    i_div_flush = 1'b0;
    chk("flush_valid_ready", o_div_ready, 1);
    chk("flush_valid_busy", o_div_busy, 0);

    start_and_wait(12);
    i_div_flush = 1'b1;
    @(negedge clk);
    i_div_flush = 1'b0;
    chk("flush_ready", o_div_ready, 1);
    chk("flush_busy", o_div_busy, 0);
    expect_quiet("flush_no_valid", XLEN + 6);
    run_op(2'b01, 32'd9, 32'd3, 5'd15, 0);

    start_and_wait(10);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    expect_quiet("rst_no_valid", XLEN + 6);

    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom);
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = MINV; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(1, 15) | (b & 32'h8000_0000);
        default: ;
      endcase
      run_op(op, a, b, TAG_W'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
